// File: rtl/fifo8x9_ctrl_pkg.sv
// Shared types and sizing for the FIFO8x9 sequencer: state encoding,
// memory strobe bundle, and the depth/width/counter defaults.
package fifo8x9_ctrl_pkg;

   localparam int DEPTH = 8;   // memory locations, count saturates here
   localparam int WIDTH = 9;   // data width
   localparam int CNT_W = 4;   // holds 0..DEPTH

   typedef enum logic [3:0] {
      S_INIT_R = 4'd0,
      S_INIT_W = 4'd1,
      S_IDLE   = 4'd2,
      S_WR     = 4'd3,
      S_WINC   = 4'd4,
      S_RD     = 4'd5,
      S_RINC   = 4'd6,
      S_FL_R   = 4'd7,
      S_FL_W   = 4'd8
   } state_e;

   // Memory control strobes; at most one is set in any cycle.
   typedef struct packed {
      logic rd_ptr_clr;
      logic wr_ptr_clr;
      logic rd_inc;
      logic wr_inc;
      logic wren;
      logic rden;
   } strobes_t;

endpackage

// File: rtl/fifo8x9_ctrl_if.sv
// Producer/consumer handshake bundle for the FIFO8x9 sequencer.
// Handshake rules: push_req is held with push_data stable until a one-cycle
// push_ack pulse marks the word committed; pop_req is held until a one-cycle
// pop_valid pulse marks pop_data as new. Dropping a request after its
// ack/valid pulse and before the next clock edge avoids a second transfer.
interface fifo8x9_ctrl_if;
   import fifo8x9_ctrl_pkg::*;

   logic             push_req;
   logic [WIDTH-1:0] push_data;
   logic             push_ack;
   logic             pop_req;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;

   modport master (
      output push_req, push_data, pop_req,
      input  push_ack, pop_data, pop_valid
   );

   modport slave (
      input  push_req, push_data, pop_req,
      output push_ack, pop_data, pop_valid
   );

endinterface

// File: rtl/fifo_rr_arb2.sv
// Two-requester round-robin arbiter. req[0] is push, req[1] is pop.
// Only a contested grant (both requesting with advance) flips priority;
// after reset push has priority.
module fifo_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic pop_last_q, pop_last_d;

   // Grant: priority goes to the requester that did not win the last contest.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = pop_last_q ? 2'b01 : 2'b10;
      end
      pop_last_d = advance ? gnt[1] : pop_last_q;
   end

   // Priority register; reset value lets push win the first contest.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_last_q <= 1'b1;
      end else begin
         pop_last_q <= pop_last_d;
      end
   end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Sequencer/arbiter for the FIFO8x9 memory. Converts push/pop handshakes into
// registered one-hot memory strobes and tracks occupancy, full, empty, flush.
module fifo8x9_ctrl
   import fifo8x9_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   fifo8x9_ctrl_if.slave    bus,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             busy,
   output logic             RdPtrClr,
   output logic             WrPtrClr,
   output logic             RdInc,
   output logic             WrInc,
   output logic             wren,
   output logic             rden,
   output logic [WIDTH-1:0] fifo_din,
   input  logic [WIDTH-1:0] fifo_dout,
   output state_e           state_dbg
);

   state_e           state_q, state_d;
   strobes_t         strb_q, strb_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             busy_q, busy_d;
   logic             push_ack_q, push_ack_d;
   logic             pop_valid_q, pop_valid_d;
   logic [WIDTH-1:0] pop_data_q, pop_data_d;
   logic [WIDTH-1:0] fifo_din_q, fifo_din_d;
   logic [1:0]       arb_req, arb_gnt;
   logic             arb_adv;

   // Occupancy guards eligibility; pointers are never compared.
   assign arb_req = {bus.pop_req & ~empty_q, bus.push_req & ~full_q};

   fifo_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req),
      .advance (arb_adv),
      .gnt     (arb_gnt)
   );

   // Next state: INIT_R waits until its clear strobe has been issued; IDLE
   // gives flush priority over the arbitrated push/pop.
   always_comb begin
      state_d = state_q;
      arb_adv = 1'b0;
      unique case (state_q)
         S_INIT_R: if (strb_q.rd_ptr_clr) state_d = S_INIT_W;
         S_INIT_W: state_d = S_IDLE;
         S_IDLE: begin
            if (flush) begin
               state_d = S_FL_R;
            end else begin
               arb_adv = &arb_req;
               if (arb_gnt[0])      state_d = S_WR;
               else if (arb_gnt[1]) state_d = S_RD;
            end
         end
         S_WR:     state_d = S_WINC;
         S_WINC:   state_d = S_IDLE;
         S_RD:     state_d = S_RINC;
         S_RINC:   state_d = S_IDLE;
         S_FL_R:   state_d = S_FL_W;
         S_FL_W:   state_d = S_IDLE;
         default:  state_d = S_INIT_R;
      endcase
   end

   // Register inputs decoded from the next state so every output is aligned
   // with the state it belongs to.
   always_comb begin
      strb_d = '0;
      case (state_d)
         S_INIT_R, S_FL_R: strb_d.rd_ptr_clr = 1'b1;
         S_INIT_W, S_FL_W: strb_d.wr_ptr_clr = 1'b1;
         S_WR:             strb_d.wren       = 1'b1;
         S_WINC:           strb_d.wr_inc     = 1'b1;
         S_RD:             strb_d.rden       = 1'b1;
         S_RINC:           strb_d.rd_inc     = 1'b1;
         default:          strb_d            = '0;
      endcase

      count_d = count_q;
      if (state_d == S_WINC)      count_d = count_q + 1'b1;
      else if (state_d == S_RINC) count_d = count_q - 1'b1;
      else if (state_d == S_FL_W) count_d = '0;

      full_d      = (count_d == CNT_W'(DEPTH));
      empty_d     = (count_d == '0);
      busy_d      = (state_d != S_IDLE);
      push_ack_d  = (state_d == S_WINC);
      pop_valid_d = (state_d == S_RINC);
      pop_data_d  = (state_q == S_RD) ? fifo_dout : pop_data_q;
      fifo_din_d  = (state_q == S_IDLE && state_d == S_WR) ? bus.push_data : fifo_din_q;
   end

   // State, counter and output registers; reset abandons any partial op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_INIT_R;
         strb_q      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         busy_q      <= 1'b1;
         push_ack_q  <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         fifo_din_q  <= '0;
      end else begin
         state_q     <= state_d;
         strb_q      <= strb_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         busy_q      <= busy_d;
         push_ack_q  <= push_ack_d;
         pop_valid_q <= pop_valid_d;
         pop_data_q  <= pop_data_d;
         fifo_din_q  <= fifo_din_d;
      end
   end

   assign RdPtrClr      = strb_q.rd_ptr_clr;
   assign WrPtrClr      = strb_q.wr_ptr_clr;
   assign RdInc         = strb_q.rd_inc;
   assign WrInc         = strb_q.wr_inc;
   assign wren          = strb_q.wren;
   assign rden          = strb_q.rden;
   assign count         = count_q;
   assign full          = full_q;
   assign empty         = empty_q;
   assign busy          = busy_q;
   assign fifo_din      = fifo_din_q;
   assign bus.push_ack  = push_ack_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.pop_data  = pop_data_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: behavioural 8x9 memory, transaction-level
// reference (word queue + round-robin bit), directed and random traffic.
module tb_fifo8x9_ctrl;
   import fifo8x9_ctrl_pkg::*;

   logic             clk, rst, flush;
   logic [CNT_W-1:0] count;
   logic             full, empty, busy;
   logic             RdPtrClr, WrPtrClr, RdInc, WrInc, wren, rden;
   logic [WIDTH-1:0] fifo_din, fifo_dout;
   state_e           state_dbg;

   fifo8x9_ctrl_if bus();

   fifo8x9_ctrl dut (
      .clk(clk), .rst(rst), .bus(bus), .flush(flush), .count(count),
      .full(full), .empty(empty), .busy(busy),
      .RdPtrClr(RdPtrClr), .WrPtrClr(WrPtrClr), .RdInc(RdInc), .WrInc(WrInc),
      .wren(wren), .rden(rden), .fifo_din(fifo_din), .fifo_dout(fifo_dout),
      .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- memory model (priority-decoded strobes) ----------------
   logic [WIDTH-1:0] mem [8];
   logic [2:0]       mrd, mwr;
   assign fifo_dout = rden ? mem[mrd] : '0;

   always @(posedge clk) begin
      if (RdPtrClr)      mrd <= 3'd0;
      else if (WrPtrClr) mwr <= 3'd0;
      else if (RdInc)    mrd <= mrd + 3'd1;
      else if (WrInc)    mwr <= mwr + 3'd1;
      else if (wren)     mem[mwr] <= fifo_din;
   end

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   logic [WIDTH-1:0] exp_q[$];
   bit   grant_log[$];
   bit   rr_pop_next, phase4;
   bit   prev_wren, prev_rden, prev_push_elig, prev_pop_elig, prev_flush;
   int   ack_cnt = 0, rden_cnt = 0, strobe_ones;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         rr_pop_next = 1'b0;
         prev_wren = 0; prev_rden = 0; prev_push_elig = 0; prev_pop_elig = 0; prev_flush = 0;
      end else begin
         strobe_ones = $countones({RdPtrClr, WrPtrClr, RdInc, WrInc, wren, rden});
         check_eq("strobe_onehot", 32'(strobe_ones <= 1), 1);
         check_eq("push_ack_after_wren", 32'(bus.push_ack), 32'(prev_wren));
         check_eq("wrinc_after_wren", 32'(WrInc), 32'(prev_wren));
         check_eq("pop_valid_after_rden", 32'(bus.pop_valid), 32'(prev_rden));
         check_eq("rdinc_after_rden", 32'(RdInc), 32'(prev_rden));
         if (wren) begin
            check_eq("fifo_din", 32'(fifo_din), 32'(bus.push_data));
            check_eq("push_grant_eligible", 32'(prev_push_elig), 1);
         end
         if (rden) begin
            check_eq("pop_grant_eligible", 32'(prev_pop_elig), 1);
            rden_cnt++;
         end
         if (wren || rden) begin
            check_eq("flush_priority", 32'(prev_flush), 0);
            if (prev_push_elig && prev_pop_elig) begin
               check_eq("rr_grant_is_pop", 32'(rden), 32'(rr_pop_next));
               rr_pop_next = ~rr_pop_next;
            end
            if (phase4) begin
               grant_log.push_back(rden);
               check_eq("rr_count_range", 32'(count >= 3 && count <= 4), 1);
            end
         end
         if (bus.push_ack) begin
            exp_q.push_back(bus.push_data);
            ack_cnt++;
         end
         if (bus.pop_valid) begin
            if (exp_q.size() == 0) check_eq("pop_underflow", 32'(bus.pop_data), 32'h1_0000);
            else check_eq("pop_data_order", 32'(bus.pop_data), 32'(exp_q.pop_front()));
         end
         if (WrPtrClr) exp_q.delete();
         check_eq("count", 32'(count), 32'(exp_q.size()));
         check_eq("full", 32'(full), 32'(exp_q.size() == DEPTH));
         check_eq("empty", 32'(empty), 32'(exp_q.size() == 0));
         prev_wren      = wren;
         prev_rden      = rden;
         prev_flush     = flush;
         prev_push_elig = bus.push_req && (exp_q.size() < DEPTH);
         prev_pop_elig  = bus.pop_req && (exp_q.size() > 0);
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic do_push(input logic [WIDTH-1:0] d, input int max_cyc, output bit ok, output int lat);
      ok = 0; lat = 0;
      bus.push_data = d;
      bus.push_req  = 1'b1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (bus.push_ack) begin ok = 1; lat = i; break; end
      end
      @(posedge clk); #1;
      bus.push_req = 1'b0;
   endtask

   task automatic do_pop(input int max_cyc, output bit ok, output int lat);
      ok = 0; lat = 0;
      bus.pop_req = 1'b1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (bus.pop_valid) begin ok = 1; lat = i; break; end
      end
      @(posedge clk); #1;
      bus.pop_req = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   bit ok, ok_p, ok_c, seen;
   int lat, lat_p, lat_c, a0, r0;

   initial begin
      rst = 1'b1; flush = 1'b0;
      bus.push_req = 1'b0; bus.pop_req = 1'b0; bus.push_data = '0;

      // 1: reset values and init sequence
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_empty", 32'(empty), 1);
      check_eq("rst_full", 32'(full), 0);
      check_eq("rst_strobes", 32'({RdPtrClr, WrPtrClr, RdInc, WrInc, wren, rden}), 0);
      check_eq("rst_ack_valid", 32'({bus.push_ack, bus.pop_valid}), 0);
      check_eq("rst_pop_data", 32'(bus.pop_data), 0);
      check_eq("rst_fifo_din", 32'(fifo_din), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (RdPtrClr) begin seen = 1; break; end
      end
      check_eq("init_rdptrclr_seen", 32'(seen), 1);
      @(negedge clk);
      check_eq("init_wrptrclr", 32'(WrPtrClr), 1);
      check_eq("init_rdptrclr_off", 32'(RdPtrClr), 0);
      @(negedge clk);
      check_eq("init_busy", 32'(busy), 0);
      check_eq("init_empty", 32'(empty), 1);
      @(posedge clk); #1;

      // 2: single push then pop with latency
      do_push(9'h1A5, 20, ok, lat);
      check_eq("t2_push_ok", 32'(ok), 1);
      check_eq("t2_push_latency", 32'(lat), 3);
      check_eq("t2_count1", 32'(count), 1);
      do_pop(20, ok, lat);
      check_eq("t2_pop_ok", 32'(ok), 1);
      check_eq("t2_pop_latency", 32'(lat), 3);
      check_eq("t2_pop_data", 32'(bus.pop_data), 32'h1A5);
      check_eq("t2_count0", 32'(count), 0);

      // 3: fill to full, 9th push stalls until a pop
      for (int i = 0; i < 8; i++) begin
         do_push(9'(9'h100 + i), 20, ok, lat);
         check_eq("t3_fill_ok", 32'(ok), 1);
      end
      check_eq("t3_full", 32'(full), 1);
      check_eq("t3_count8", 32'(count), 8);
      fork
         do_push(9'h108, 100, ok_p, lat_p);
         begin
            a0 = ack_cnt;
            repeat (10) @(negedge clk);
            check_eq("t3_stall_no_ack", 32'(ack_cnt), 32'(a0));
            @(posedge clk); #1;
            do_pop(20, ok_c, lat_c);
            check_eq("t3_pop_ok", 32'(ok_c), 1);
            check_eq("t3_first_pop", 32'(bus.pop_data), 32'h100);
         end
      join
      check_eq("t3_ninth_acked", 32'(ok_p), 1);
      for (int i = 0; i < 8; i++) begin
         do_pop(20, ok, lat);
         check_eq("t3_drain_ok", 32'(ok), 1);
      end
      check_eq("t3_last_pop", 32'(bus.pop_data), 32'h108);
      check_eq("t3_empty", 32'(empty), 1);

      // 4: contested traffic at count 3 alternates push, pop, ...
      for (int i = 0; i < 3; i++) do_push(9'($urandom_range(0, 511)), 20, ok, lat);
      grant_log.delete();
      phase4 = 1;
      fork
         for (int i = 0; i < 6; i++) do_push(9'($urandom_range(0, 511)), 40, ok_p, lat_p);
         for (int i = 0; i < 6; i++) do_pop(40, ok_c, lat_c);
      join
      phase4 = 0;
      check_eq("t4_grants", 32'(grant_log.size()), 12);
      for (int i = 0; i < grant_log.size(); i++) check_eq("t4_rr_order", 32'(grant_log[i]), 32'(i % 2));
      check_eq("t4_count3", 32'(count), 3);

      // 5: pop on empty waits; flush during a write
      for (int i = 0; i < 3; i++) do_pop(20, ok, lat);
      r0 = rden_cnt;
      do_pop(20, ok, lat);
      check_eq("t5_empty_pop_no_valid", 32'(ok), 0);
      check_eq("t5_empty_pop_no_rden", 32'(rden_cnt), 32'(r0));
      do_push(9'h055, 20, ok, lat);
      do_push(9'h0AA, 20, ok, lat);
      fork
         do_push(9'h1F0, 20, ok_p, lat_p);
         begin
            @(posedge clk); #1;
            flush = 1'b1;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (WrPtrClr) begin seen = 1; break; end
            end
            check_eq("t5_flush_clear_seen", 32'(seen), 1);
            @(posedge clk); #1;
            flush = 1'b0;
         end
      join
      check_eq("t5_write_acked", 32'(ok_p), 1);
      check_eq("t5_write_latency", 32'(lat_p), 3);
      check_eq("t5_flush_count", 32'(count), 0);
      check_eq("t5_flush_empty", 32'(empty), 1);

      // 6: random concurrent traffic, pointers wrap several times
      fork
         for (int i = 0; i < 24; i++) begin
            wait_cycles($urandom_range(0, 3));
            do_push(9'($urandom_range(0, 511)), 300, ok, lat);
            check_eq("t6_push_ok", 32'(ok), 1);
         end
         for (int i = 0; i < 24; i++) begin
            wait_cycles($urandom_range(0, 4));
            do_pop(300, ok_c, lat_c);
            check_eq("t6_pop_ok", 32'(ok_c), 1);
         end
      join
      check_eq("t6_empty", 32'(empty), 1);

      // 7: reset during a write discards it
      a0 = ack_cnt;
      bus.push_data = 9'h133;
      bus.push_req  = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.push_req = 1'b0;
      @(negedge clk);
      check_eq("t7_wren_before_abort", 32'(wren), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("t7_rst_pop_data", 32'(bus.pop_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!busy) begin seen = 1; break; end
      end
      check_eq("t7_idle_after_reset", 32'(seen), 1);
      check_eq("t7_no_ack", 32'(ack_cnt), 32'(a0));
      check_eq("t7_count0", 32'(count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
